alu_cmd_sequencer: RTL and testbench

//  Upstream command stage for the 16-bit accumulator ALU. Buffers operation commands in a small FIFO.

---
 rtl/alu_cmd_sequencer.sv | 111 +++++++++++
 tb/tb_alu_cmd_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: buffers ALU commands in a FIFO, issues them one at a time to the
// accumulator ALU, and returns each captured result through a valid/ready port.
module alu_cmd_sequencer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [3:0]               cmd_op,
    input  logic [DATA_W-1:0]        cmd_a,
    input  logic [DATA_W-1:0]        cmd_b,
    input  logic [1:0]               cmd_src_b,
    input  logic [ACC_W-1:0]         acc_val,
    output logic [DATA_W-1:0]        alu_A,
    output logic [DATA_W-1:0]        alu_B,
    output logic [1:0]               alu_muxA,
    output logic [3:0]               alu_muxB,
    output logic [3:0]               alu_op,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ACC_W-1:0]         rsp_data,
    output logic                     rsp_err,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
    state_t state, state_n;

    logic [3:0]        q_op  [DEPTH];
    logic [DATA_W-1:0] q_a   [DEPTH];
    logic [DATA_W-1:0] q_b   [DEPTH];
    logic [1:0]        q_src [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic [3:0]        cur_op;
    logic [DATA_W-1:0] cur_a, cur_b, b_sel;
    logic [1:0]        cur_src;
    logic              sticky_err, err_pred, push, pop, issue;

    assign cmd_ready  = count < CW'(DEPTH);
    assign fifo_count = count;
    assign push       = cmd_valid && cmd_ready;
    assign pop        = state_n == ISSUE;
    assign rsp_valid  = state == RESP;

    // Source 3 is reserved and behaves like source 0 (cmd_b).
    assign b_sel    = cur_src == 2'd1 ? acc_val[DATA_W-1:0] : cur_src == 2'd2 ? '0 : cur_b;
    assign err_pred = (cur_op == 4'd1 && b_sel > cur_a) || (cur_op == 4'd3 && b_sel == '0);

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (count != '0) state_n = ISSUE;
            ISSUE:   state_n = CAPTURE;
            CAPTURE: state_n = RESP;
            RESP:    if (rsp_ready) state_n = (count != '0) ? ISSUE : IDLE;
        endcase
    end

    // Reset is visible on the ALU drive immediately so the accumulator clears alongside us.
    always_comb begin
        issue    = reset && state == ISSUE;
        alu_op   = !reset ? 4'd14 : issue ? cur_op : 4'd13;
        alu_muxA = issue ? 2'b10 : 2'b01;
        alu_muxB = !issue ? 4'b0001 : cur_src == 2'd1 ? 4'b0010 : cur_src == 2'd2 ? 4'b1000 : 4'b0100;
        alu_A    = issue ? cur_a : '0;
        alu_B    = (issue && (cur_src == 2'd0 || cur_src == 2'd3)) ? cur_b : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            sticky_err <= 1'b0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            state  <= state_n;
            count  <= count + CW'(push) - CW'(pop);
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (state == ISSUE) sticky_err <= (cur_op == 4'd14) ? 1'b0 : (sticky_err | err_pred);
            if (state == CAPTURE) begin
                rsp_data <= (cur_op == 4'd14) ? '0 : acc_val;
                rsp_err  <= sticky_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_op[wr_ptr]  <= cmd_op;
            q_a[wr_ptr]   <= cmd_a;
            q_b[wr_ptr]   <= cmd_b;
            q_src[wr_ptr] <= cmd_src_b;
        end
        if (pop) begin
            cur_op  <= q_op[rd_ptr];
            cur_a   <= q_a[rd_ptr];
            cur_b   <= q_b[rd_ptr];
            cur_src <= q_src[rd_ptr];
        end
    end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed scenarios against a small accumulator ALU model.
module tb_alu_cmd_sequencer;
    logic        clk = 1'b0, reset = 1'b0, cmd_valid = 1'b0, rsp_ready = 1'b0;
    logic [3:0]  cmd_op = '0;
    logic [15:0] cmd_a = '0, cmd_b = '0;
    logic [1:0]  cmd_src_b = '0;
    logic [31:0] acc_val, rsp_data;
    logic [15:0] alu_A, alu_B, mb;
    logic [1:0]  alu_muxA;
    logic [3:0]  alu_muxB, alu_op;
    logic        cmd_ready, rsp_valid, rsp_err;
    logic [2:0]  fifo_count;
    logic [31:0] acc;
    int          n_cmp = 0, n_bad = 0, cyc = 0;
    int          issue_cyc[$];

    alu_cmd_sequencer dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_src_b(cmd_src_b),
        .acc_val(acc_val), .alu_A(alu_A), .alu_B(alu_B), .alu_muxA(alu_muxA),
        .alu_muxB(alu_muxB), .alu_op(alu_op), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (alu_muxA == 2'b10) issue_cyc.push_back(cyc);

    // Accumulator ALU model; error cases leave the accumulator unchanged.
    assign mb = alu_muxB == 4'b0100 ? alu_B : alu_muxB == 4'b0010 ? acc[15:0] : 16'd0;
    assign acc_val = acc;
    always @(posedge clk) begin
        if (alu_op == 4'd14) acc <= '0;
        else if (alu_muxA == 2'b10) begin
            case (alu_op)
                4'd0: acc <= 32'(alu_A) + 32'(mb);
                4'd1: if (mb <= alu_A) acc <= 32'(alu_A - mb);
                4'd2: acc <= 32'(alu_A) * 32'(mb);
                4'd3: if (mb != 16'd0) acc <= 32'(alu_A / mb);
                default: ;
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input logic [1:0] src);
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_src_b = src;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(output logic [31:0] d, output logic e, output bit ok);
        ok = 1'b0; d = '0; e = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            step();
            if (rsp_valid) begin
                ok = 1'b1; d = rsp_data; e = rsp_err;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; rsp_ready = 1'b0;
        repeat (3) step();
        n_cmp++; if ({fifo_count, rsp_valid, rsp_err, cmd_ready} !== {3'd0, 1'b0, 1'b0, 1'b1}) begin n_bad++; $display("FAIL reset_flags: got %b expected %b", {fifo_count, rsp_valid, rsp_err, cmd_ready}, 6'b000001); end
        n_cmp++; if (rsp_data !== 32'd0) begin n_bad++; $display("FAIL reset_data: got %0d expected 0", rsp_data); end
        n_cmp++; if ({alu_op, alu_muxA, alu_muxB, alu_A, alu_B} !== {4'd14, 2'b01, 4'b0001, 16'd0, 16'd0}) begin n_bad++; $display("FAIL reset_drive: got op=%0d mA=%b mB=%b A=%0d B=%0d expected op=14 mA=01 mB=0001 A=0 B=0", alu_op, alu_muxA, alu_muxB, alu_A, alu_B); end
        reset = 1'b1;
        step();
        n_cmp++; if (alu_op !== 4'd13) begin n_bad++; $display("FAIL idle_op: got %0d expected 13", alu_op); end
    endtask

    task automatic test_single();
        rsp_ready = 1'b1;
        push(4'd0, 16'd5, 16'd6, 2'd0);
        n_cmp++; if (alu_op !== 4'd13) begin n_bad++; $display("FAIL t1_push_cycle_op: got %0d expected 13", alu_op); end
        step();
        n_cmp++; if ({alu_op, alu_muxA, alu_muxB, alu_A, alu_B} !== {4'd0, 2'b10, 4'b0100, 16'd5, 16'd6}) begin n_bad++; $display("FAIL t1_issue: got op=%0d mA=%b mB=%b A=%0d B=%0d expected op=0 mA=10 mB=0100 A=5 B=6", alu_op, alu_muxA, alu_muxB, alu_A, alu_B); end
        step();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL t1_early_valid: got %b expected 0", rsp_valid); end
        step();
        n_cmp++; if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b0, 32'd11}) begin n_bad++; $display("FAIL t1_rsp: got v=%b e=%b d=%0d expected v=1 e=0 d=11", rsp_valid, rsp_err, rsp_data); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] d; logic e; bit ok;
        issue_cyc.delete();
        push(4'd0, 16'd42, 16'd0, 2'd1);
        push(4'd1, 16'd823, 16'd0, 2'd1);
        get_rsp(d, e, ok);
        n_cmp++; if (!ok || d !== 32'd53 || e !== 1'b0) begin n_bad++; $display("FAIL t2_first: got ok=%b d=%0d e=%b expected d=53 e=0", ok, d, e); end
        get_rsp(d, e, ok);
        n_cmp++; if (!ok || d !== 32'd770 || e !== 1'b0) begin n_bad++; $display("FAIL t2_second: got ok=%b d=%0d e=%b expected d=770 e=0", ok, d, e); end
        n_cmp++; if (issue_cyc.size() != 2 || issue_cyc[1] - issue_cyc[0] != 3) begin n_bad++; $display("FAIL t2_issue_spacing: got %0d issues expected 2 issues 3 cycles apart", issue_cyc.size()); end
        step();
    endtask

    task automatic test_sticky_clear();
        logic [31:0] d; logic e; bit ok;
        push(4'd1, 16'd12, 16'd0, 2'd1);
        push(4'd0, 16'd1, 16'd1, 2'd0);
        push(4'd14, 16'd0, 16'd0, 2'd0);
        get_rsp(d, e, ok);
        n_cmp++; if (!ok || e !== 1'b1) begin n_bad++; $display("FAIL t3_underflow_err: got ok=%b e=%b expected e=1", ok, e); end
        get_rsp(d, e, ok);
        n_cmp++; if (!ok || d !== 32'd2 || e !== 1'b1) begin n_bad++; $display("FAIL t3_sticky: got ok=%b d=%0d e=%b expected d=2 e=1", ok, d, e); end
        get_rsp(d, e, ok);
        n_cmp++; if (!ok || d !== 32'd0 || e !== 1'b0) begin n_bad++; $display("FAIL t3_op14: got ok=%b d=%0d e=%b expected d=0 e=0", ok, d, e); end
        step();
    endtask

    task automatic test_backpressure();
        logic [31:0] d; logic e; bit ok; logic rdy;
        int accepted = 0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cmd_valid = 1'b1; cmd_op = 4'd0; cmd_a = 16'(100 + i); cmd_b = 16'd10; cmd_src_b = 2'd0;
            rdy = cmd_ready;
            step();
            if (rdy) accepted++;
        end
        cmd_valid = 1'b0;
        n_cmp++; if (accepted != 5 || cmd_ready !== 1'b0 || fifo_count !== 3'd4) begin n_bad++; $display("FAIL t4_full: got accepted=%0d ready=%b count=%0d expected accepted=5 ready=0 count=4", accepted, cmd_ready, fifo_count); end
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd110) begin n_bad++; $display("FAIL t4_stall_first: got v=%b d=%0d expected v=1 d=110", rsp_valid, rsp_data); end
        repeat (4) step();
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd110) begin n_bad++; $display("FAIL t4_stall_hold: got v=%b d=%0d expected v=1 d=110", rsp_valid, rsp_data); end
        rsp_ready = 1'b1;
        step();
        for (int i = 1; i < 5; i++) begin
            get_rsp(d, e, ok);
            n_cmp++; if (!ok || d !== 32'(110 + i)) begin n_bad++; $display("FAIL t4_drain_%0d: got ok=%b d=%0d expected d=%0d", i, ok, d, 110 + i); end
        end
        repeat (3) step();
        n_cmp++; if (rsp_valid !== 1'b0 || fifo_count !== 3'd0) begin n_bad++; $display("FAIL t4_empty: got v=%b count=%0d expected v=0 count=0", rsp_valid, fifo_count); end
    endtask

    task automatic test_div_zero();
        logic [31:0] d; logic e; bit ok;
        push(4'd3, 16'd2048, 16'd0, 2'd0);
        push(4'd2, 16'd2048, 16'd16, 2'd0);
        get_rsp(d, e, ok);
        n_cmp++; if (!ok || e !== 1'b1) begin n_bad++; $display("FAIL t5_div0_err: got ok=%b e=%b expected e=1", ok, e); end
        get_rsp(d, e, ok);
        n_cmp++; if (!ok || d !== 32'd32768 || e !== 1'b1) begin n_bad++; $display("FAIL t5_sticky_mul: got ok=%b d=%0d e=%b expected d=32768 e=1", ok, d, e); end
        step();
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic e; bit ok;
        int seen = 0;
        rsp_ready = 1'b1;
        push(4'd0, 16'd1, 16'd1, 2'd0);
        push(4'd0, 16'd2, 16'd2, 2'd0);
        push(4'd0, 16'd3, 16'd3, 2'd0);
        n_cmp++; if (fifo_count !== 3'd2 || rsp_valid !== 1'b0) begin n_bad++; $display("FAIL t6_pre: got count=%0d v=%b expected count=2 v=0", fifo_count, rsp_valid); end
        reset = 1'b0;
        step();
        n_cmp++; if ({fifo_count, rsp_valid, alu_op} !== {3'd0, 1'b0, 4'd14}) begin n_bad++; $display("FAIL t6_flush: got count=%0d v=%b op=%0d expected count=0 v=0 op=14", fifo_count, rsp_valid, alu_op); end
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (rsp_valid) seen++;
        end
        n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL t6_no_rsp: got %0d valid cycles expected 0", seen); end
        push(4'd0, 16'd1, 16'd2, 2'd0);
        get_rsp(d, e, ok);
        n_cmp++; if (!ok || d !== 32'd3 || e !== 1'b0) begin n_bad++; $display("FAIL t6_after: got ok=%b d=%0d e=%b expected d=3 e=0", ok, d, e); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_sticky_clear();
        test_backpressure();
        test_div_zero();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
